fdiv16: RTL

Iterative half-precision floating-point divider that computes x / y with IEEE 754 binary16 encoding, selectable rounding, and exception flags. It is the multi-cycle companion to the combinational fma16 datapath in the floating-point exercise tree. It uses the same operand format, rounding-mode encoding and flag conventions, and adds a divide-by-zero flag. Requests use a start/busy/done handshake with a fixed latency.

---
 rtl/fdiv16.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/fdiv16.sv
// Iterative binary16 divider: radix-2 restoring, 13 quotient bits, fixed 14-cycle latency.
// Special operands are resolved at acceptance but still walk the DIV/ROUND sequence.
module fdiv16 (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic [1:0]  roundmode,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic [4:0]  flags
);

  typedef enum logic [1:0] {IDLE, DIV, RND} state_t;
  localparam logic [1:0] RZ = 2'b00, RNE = 2'b01, RM = 2'b10, RP = 2'b11;

  state_t state, state_nxt;
  logic [3:0] cnt;
  logic        sgn;
  logic signed [6:0] exq;
  logic [11:0] rem;
  logic [10:0] my;
  logic [12:0] q;
  logic [1:0]  rm;
  logic        spc;
  logic [15:0] spc_res;
  logic [4:0]  spc_flg;

  // operand decode (combinational on live inputs, used only at acceptance)
  logic sx, sy, zx, zy, ix, iy, nx_, ny_, snan;
  logic [4:0] ex, ey;
  logic [9:0] fx, fy;
  logic        a_spc;
  logic [15:0] a_res;
  logic [4:0]  a_flg;

  always_comb begin
    sx = x[15]; ex = x[14:10]; fx = x[9:0];
    sy = y[15]; ey = y[14:10]; fy = y[9:0];
    zx = (ex == 5'd0);  zy = (ey == 5'd0);
    ix = (ex == 5'd31) && (fx == 10'd0);
    iy = (ey == 5'd31) && (fy == 10'd0);
    nx_ = (ex == 5'd31) && (fx != 10'd0);
    ny_ = (ey == 5'd31) && (fy != 10'd0);
    snan = (nx_ && !fx[9]) || (ny_ && !fy[9]);
    a_spc = 1'b1;
    a_res = 16'h0000;
    a_flg = 5'b00000;
    if (nx_ || ny_) begin
      a_res = 16'h7E00;
      a_flg = {snan, 4'b0000};
    end else if ((zx && zy) || (ix && iy)) begin
      a_res = 16'h7E00;
      a_flg = 5'b10000;
    end else if (ix) begin
      a_res = {sx ^ sy, 15'h7C00};
    end else if (zy) begin
      a_res = {sx ^ sy, 15'h7C00};
      a_flg = 5'b01000;
    end else if (iy || zx) begin
      a_res = {sx ^ sy, 15'h0000};
    end else begin
      a_spc = 1'b0;
    end
  end

  // one restoring step
  logic        ge;
  logic [11:0] rem_sub;
  always_comb begin
    ge      = (rem >= {1'b0, my});
    rem_sub = rem - {1'b0, my};
  end

  // normalize, round, range check
  logic [9:0]  man;
  logic        g, s, inc, ovf, unf, of_max;
  logic [10:0] man_r;
  logic signed [6:0] e_n, e_r;
  logic [15:0] r_res;
  logic [4:0]  r_flg;

  always_comb begin
    if (q[12]) begin
      man = q[11:2]; g = q[1]; s = q[0] | (rem != 12'd0); e_n = exq;
    end else begin
      man = q[10:1]; g = q[0]; s = (rem != 12'd0);        e_n = exq - 7'sd1;
    end
    case (rm)
      RZ:      inc = 1'b0;
      RNE:     inc = g & (s | man[0]);
      RM:      inc = sgn & (g | s);
      default: inc = ~sgn & (g | s);
    endcase
    man_r  = {1'b0, man} + {10'd0, inc};
    e_r    = e_n + (man_r[10] ? 7'sd1 : 7'sd0);
    ovf    = (e_r >= 7'sd31);
    unf    = (e_r <= 7'sd0);
    of_max = (rm == RZ) || (rm == RM && !sgn) || (rm == RP && sgn);
    if (ovf) begin
      r_res = {sgn, of_max ? 15'h7BFF : 15'h7C00};
      r_flg = 5'b00101;
    end else if (unf) begin
      r_res = {sgn, 15'h0000};
      r_flg = 5'b00011;
    end else begin
      r_res = {sgn, e_r[4:0], man_r[9:0]};
      r_flg = {4'b0000, g | s};
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = DIV;
      DIV:     if (cnt == 4'd12) state_nxt = RND;
      RND:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= 1'b0; done <= 1'b0; result <= 16'h0000; flags <= 5'b0;
      cnt <= 4'd0; sgn <= 1'b0; exq <= 7'sd0; rem <= 12'd0; my <= 11'd0;
      q <= 13'd0; rm <= 2'b00; spc <= 1'b0; spc_res <= 16'h0000; spc_flg <= 5'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          busy    <= 1'b1;
          cnt     <= 4'd0;
          sgn     <= sx ^ sy;
          exq     <= $signed({2'b00, ex}) - $signed({2'b00, ey}) + 7'sd15;
          rem     <= {1'b0, 1'b1, fx};
          my      <= {1'b1, fy};
          q       <= 13'd0;
          rm      <= roundmode;
          spc     <= a_spc;
          spc_res <= a_res;
          spc_flg <= a_flg;
        end
        DIV: begin
          cnt <= cnt + 4'd1;
          q   <= {q[11:0], ge};
          rem <= (ge ? rem_sub : rem) << 1;
        end
        RND: begin
          busy   <= 1'b0;
          done   <= 1'b1;
          result <= spc ? spc_res : r_res;
          flags  <= spc ? spc_flg : r_flg;
        end
        default: ;
      endcase
    end
  end

endmodule
